// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage: opcodes, the canonical NOP,
// the reset vector default and the fetch FSM state encoding.
package inst_fetch_pkg;

   localparam logic [6:0]  OPC_OP_IMM       = 7'b0010011;
   // addi x0, x0, 0
   localparam logic [31:0] INST_NOP         = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; push is accepted while full if a pop
// happens in the same cycle, so the count stays unchanged.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push, do_pop;

   assign o_full  = (count == DEPTH_C);
   assign o_empty = (count == '0);
   assign o_count = count;
   assign o_rdata = mem[rd_ptr];

   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push && !i_flush) mem[wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word fetches, buffers in-order responses
// and presents them to decode; redirects flush the buffer and drop stale data.
//
// state | meaning
// BOOT  | one idle cycle after reset release
// FETCH | issue requests while buffer + in-flight has room
// DRAIN | no requests; drop responses of pre-redirect requests
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = 2,
   parameter logic [31:0] NOP_INST  = INST_NOP
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   output logic        o_inst_valid,
   output logic [31:0] o_inst_data,
   output logic [31:0] o_inst_pc
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam int DW = CW + 1;
   localparam logic [DW-1:0] DEPTH_W = DW'(BUF_DEPTH);

   fetch_state_e  state_q, state_next;
   logic [31:0]   pc_q;
   logic [CW-1:0] discard_q, discard_next;
   logic [CW-1:0] outstanding, outstanding_next, ib_count;
   logic [DW-1:0] occupancy;
   logic          aq_full, aq_empty, ib_full, ib_empty;
   logic [31:0]   aq_pc;
   logic [63:0]   ib_head;
   logic          gnt_fire, rvalid_fire, ib_push, ib_pop;

   assign occupancy  = {1'b0, outstanding} + {1'b0, ib_count};
   assign o_imem_req = (state_q == ST_FETCH) && !aq_full && !ib_full && (occupancy < DEPTH_W);
   assign o_imem_addr = pc_q;

   assign gnt_fire    = o_imem_req && i_imem_gnt;
   // Responses with nothing in flight belong to pre-reset requests.
   assign rvalid_fire = i_imem_rvalid && !aq_empty;
   assign outstanding_next = outstanding + CW'(gnt_fire) - CW'(rvalid_fire);

   assign ib_push = rvalid_fire && (state_q == ST_FETCH) && !i_redirect;
   assign ib_pop  = !ib_empty && !i_stall && !i_redirect;

   // In-flight address queue; its occupancy is the outstanding count.
   fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_addr_q (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (1'b0),
      .i_push  (gnt_fire),
      .i_wdata (pc_q),
      .i_pop   (rvalid_fire),
      .o_rdata (aq_pc),
      .o_full  (aq_full),
      .o_empty (aq_empty),
      .o_count (outstanding)
   );

   fetch_fifo #(.WIDTH(64), .DEPTH(BUF_DEPTH)) u_inst_buf (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_redirect),
      .i_push  (ib_push),
      .i_wdata ({i_imem_rdata, aq_pc}),
      .i_pop   (ib_pop),
      .o_rdata (ib_head),
      .o_full  (ib_full),
      .o_empty (ib_empty),
      .o_count (ib_count)
   );

   assign o_inst_valid = !ib_empty;
   assign o_inst_data  = o_inst_valid ? ib_head[63:32] : NOP_INST;
   assign o_inst_pc    = o_inst_valid ? ib_head[31:0]  : 32'h0000_0000;

   always_comb begin
      state_next   = state_q;
      discard_next = discard_q;
      case (state_q)
         ST_BOOT:  state_next = ST_FETCH;
         ST_FETCH: state_next = ST_FETCH;
         ST_DRAIN: begin
            if (rvalid_fire && discard_q != '0) discard_next = discard_q - 1'b1;
            if (discard_next == '0) state_next = ST_FETCH;
         end
         default:  state_next = ST_BOOT;
      endcase
      // Everything still in flight after this edge is stale, including a
      // grant or response landing in the redirect cycle itself.
      if (i_redirect) begin
         discard_next = outstanding_next;
         state_next   = (outstanding_next != '0) ? ST_DRAIN : ST_FETCH;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_BOOT;
         discard_q <= '0;
         pc_q      <= RESET_PC;
      end else begin
         state_q   <= state_next;
         discard_q <= discard_next;
         if (i_redirect)    pc_q <= align_word(i_redirect_pc);
         else if (gnt_fire) pc_q <= pc_q + 32'd4;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: random memory timing and decode
// behaviour checked against a queue-based reference model, plus directed cases.
module tb_inst_fetch;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt, i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        i_stall;
   logic        o_inst_valid;
   logic [31:0] o_inst_data, o_inst_pc;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .i_clk         (clk),
      .i_rst_n       (i_rst_n),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_stall       (i_stall),
      .o_inst_valid  (o_inst_valid),
      .o_inst_data   (o_inst_data),
      .o_inst_pc     (o_inst_pc)
   );

   typedef struct { logic [31:0] addr; int due; }           pend_t;
   typedef struct { logic [31:0] addr; bit stale; }         flight_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; }   ent_t;

   pend_t       pend_q[$];
   flight_t     fl_q[$];
   ent_t        fifo_q[$];
   logic [31:0] gnt_log[$];
   logic [31:0] m_pc;
   bit          m_boot;
   int          cyc, checks, errors, grants;
   int          gnt_pct, lat_min, lat_max;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit any_stale();
      foreach (fl_q[i]) if (fl_q[i].stale) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc   = RST_PC;
      m_boot = 1'b1;
      fl_q.delete();
      fifo_q.delete();
   endtask

   // Memory is cleared unless keep_mem, which leaves pre-reset responses pending.
   task automatic do_reset(input bit keep_mem);
      i_rst_n = 1'b0;
      i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
      i_redirect = 1'b0; i_redirect_pc = '0; i_stall = 1'b0;
      @(posedge clk); #1;
      check("rst_req",   32'(o_imem_req),   32'd0);
      check("rst_valid", 32'(o_inst_valid), 32'd0);
      check("rst_data",  o_inst_data,       NOP);
      check("rst_pc",    o_inst_pc,         32'd0);
      @(posedge clk); #1;
      if (!keep_mem) pend_q.delete();
      model_reset();
      i_rst_n = 1'b1;
   endtask

   // One clock: check outputs at the falling edge, drive inputs, advance the model.
   task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc);
      bit          exp_req, rv, g, gfire, pop;
      logic [31:0] rdata, req_addr;
      @(negedge clk);
      check("inst_valid", 32'(o_inst_valid), 32'(fifo_q.size() != 0));
      if (fifo_q.size() != 0) begin
         check("inst_data", o_inst_data, fifo_q[0].data);
         check("inst_pc",   o_inst_pc,   fifo_q[0].pc);
      end else begin
         check("nop_data", o_inst_data, NOP);
         check("nop_pc",   o_inst_pc,   32'd0);
      end
      exp_req = !m_boot && !any_stale() && (fl_q.size() + fifo_q.size() < DEPTH);
      check("imem_req", 32'(o_imem_req), 32'(exp_req));
      if (o_imem_req) check("imem_addr", o_imem_addr, m_pc);
      req_addr = o_imem_addr;

      rv = 1'b0; rdata = $urandom;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         rv    = 1'b1;
         rdata = mem_word(pend_q[0].addr);
         void'(pend_q.pop_front());
      end
      g = (int'($urandom_range(99)) < gnt_pct);
      gfire = o_imem_req && g;
      if (gfire) begin
         pend_q.push_back('{addr: req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
         gnt_log.push_back(req_addr);
         grants++;
      end
      i_imem_gnt = g; i_imem_rvalid = rv; i_imem_rdata = rdata;
      i_stall = stall; i_redirect = redir; i_redirect_pc = rpc;

      pop = (fifo_q.size() != 0) && !stall && !redir;
      if (pop) void'(fifo_q.pop_front());
      if (rv && fl_q.size() != 0) begin
         flight_t e = fl_q.pop_front();
         if (!e.stale && !redir) fifo_q.push_back('{data: mem_word(e.addr), pc: e.addr});
      end
      if (gfire) begin
         fl_q.push_back('{addr: m_pc, stale: redir});
         m_pc = m_pc + 32'd4;
      end
      if (redir) begin
         fifo_q.delete();
         foreach (fl_q[i]) fl_q[i].stale = 1'b1;
         m_pc = {rpc[31:2], 2'b00};
      end
      m_boot = 1'b0;
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      bit found;
      checks = 0; errors = 0; cyc = 0; grants = 0;
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      do_reset(1'b0);

      // Back-to-back fetch, one-cycle latency
      repeat (12) cycle(1'b0, 1'b0, '0);

      // Decode stalled for ten cycles from reset
      do_reset(1'b0);
      grants = 0;
      repeat (10) cycle(1'b1, 1'b0, '0);
      check("stall_grants_le2", 32'(grants <= 2), 32'd1);
      check("stall_valid",      32'(o_inst_valid), 32'd1);
      check("stall_head_pc",    o_inst_pc,         32'd0);
      repeat (8) cycle(1'b0, 1'b0, '0);

      // Redirect with two requests outstanding
      do_reset(1'b0);
      lat_min = 4; lat_max = 4;
      for (int i = 0; i < 10 && fl_q.size() < 2; i++) cycle(1'b1, 1'b0, '0);
      cycle(1'b0, 1'b1, 32'h0000_0102);
      for (int i = 0; i < 20 && !o_inst_valid; i++) cycle(1'b1, 1'b0, '0);
      check("redirect_first_pc", o_inst_pc, 32'h0000_0100);
      repeat (4) cycle(1'b0, 1'b0, '0);

      // Redirect and stall together with a full buffer
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 10 && fifo_q.size() < DEPTH; i++) cycle(1'b1, 1'b0, '0);
      check("full_before_flush", 32'(o_inst_valid), 32'd1);
      cycle(1'b1, 1'b1, 32'h0000_0200);
      check("flush_valid", 32'(o_inst_valid), 32'd0);
      check("flush_data",  o_inst_data,       NOP);

      // Fetch PC wraps past the top of the address space
      gnt_log.delete();
      cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
      repeat (6) cycle(1'b0, 1'b0, '0);
      found = 1'b0;
      for (int i = 0; i + 1 < gnt_log.size(); i++) begin
         if (!found && gnt_log[i] == 32'hFFFF_FFFC) begin
            check("pc_wrap", gnt_log[i+1], 32'h0000_0000);
            found = 1'b1;
         end
      end
      check("pc_wrap_seen", 32'(found), 32'd1);

      // Randomized traffic under several memory/decoder profiles
      for (int seg = 0; seg < 3; seg++) begin
         gnt_pct = (seg == 0) ? 100 : (seg == 1) ? 60 : 35;
         lat_min = 1;
         lat_max = seg + 1;
         for (int i = 0; i < 150; i++) begin
            bit          st, rd;
            logic [31:0] tgt;
            st  = ($urandom_range(99) < 30);
            rd  = ($urandom_range(99) < 4);
            tgt = $urandom;
            cycle(st, rd, tgt);
         end
      end

      // Reset asserted while draining stale responses
      gnt_pct = 100; lat_min = 6; lat_max = 6;
      do_reset(1'b0);
      for (int i = 0; i < 10 && fl_q.size() < 2; i++) cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, 32'h0000_0400);
      cycle(1'b0, 1'b0, '0);
      check("in_drain_req", 32'(o_imem_req), 32'd0);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("async_rst_req",   32'(o_imem_req),   32'd0);
      check("async_rst_valid", 32'(o_inst_valid), 32'd0);
      check("async_rst_data",  o_inst_data,       NOP);
      check("async_rst_pc",    o_inst_pc,         32'd0);
      do_reset(1'b1);
      gnt_pct = 0;
      for (int i = 0; i < 20 && pend_q.size() != 0; i++) cycle(1'b0, 1'b0, '0);
      check("stale_mem_drained", 32'(pend_q.size()), 32'd0);
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      gnt_log.delete();
      repeat (6) cycle(1'b0, 1'b0, '0);
      check("restart_pc", (gnt_log.size() != 0) ? gnt_log[0] : 32'hDEAD_BEEF, RST_PC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
